// File: rtl/load_store_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit_pkg                                          |
// | Description : Shared types for the load/store unit store buffer.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package load_store_unit_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ENTRY_W = DATA_W + ADDR_W + 2;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } store_width_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] address;
        store_width_t      width;
    } store_buffer_entry_t;

    typedef enum logic [0:0] {
        DRAIN_IDLE      = 1'b0,
        DRAIN_WAIT_DONE = 1'b1
    } drain_state_t;

    // Only full-word stores can satisfy a load lookup.
    function automatic logic is_word_store(input store_width_t width);
        return width == WIDTH_WORD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : store_buffer_fifo                                            |
// | Description : Circular entry storage with head/tail pointers and count.    |
// |               STORE_BUFFER_FORWARDING_EN exposes storage for lookups.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_buffer_fifo
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  store_buffer_entry_t           entry_i,
    output store_buffer_entry_t           head_entry_o,
    output logic                          full_o,
    output logic                          empty_o
`ifdef STORE_BUFFER_FORWARDING_EN
    ,
    output store_buffer_entry_t [DEPTH-1:0] entries_o,
    output logic [$clog2(DEPTH)-1:0]      head_ptr_o,
    output logic [$clog2(DEPTH):0]        count_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("store_buffer_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    store_buffer_entry_t mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is deliberately left out of reset; count alone defines validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[tail] <= entry_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_entry_o = mem[head];

`ifdef STORE_BUFFER_FORWARDING_EN
    assign head_ptr_o = head;
    assign count_o    = count;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entries
            assign entries_o[i] = mem[i];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// +----------------------------------------------------------------------------+
// | Module      : store_buffer                                                 |
// | Description : In-order store buffer with drain FSM toward the memory       |
// |               store controller. Load forwarding: STORE_BUFFER_FORWARDING_EN|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_buffer
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        push_request_i,
    input  logic [65:0] packet_i,
    output logic        full_o,
    output logic        empty_o,
    output logic        ctrl_request_o,
    output logic [31:0] ctrl_data_o,
    output logic [31:0] ctrl_address_o,
    output logic [1:0]  ctrl_width_o,
    input  logic        ctrl_idle_i,
    input  logic        ctrl_done_i,
    input  logic [31:0] fwd_address_i,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    store_buffer_entry_t push_entry;
    store_buffer_entry_t head_entry;
    drain_state_t        state;
    drain_state_t        state_next;
    logic                pop;

    assign push_entry = store_buffer_entry_t'(packet_i);

`ifdef STORE_BUFFER_FORWARDING_EN
    store_buffer_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]                head_ptr;
    logic [CNT_W-1:0]                count;
`endif

    store_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_i       (push_request_i),
        .pop_i        (pop),
        .entry_i      (push_entry),
        .head_entry_o (head_entry),
        .full_o       (full_o),
        .empty_o      (empty_o)
`ifdef STORE_BUFFER_FORWARDING_EN
        ,
        .entries_o    (entries),
        .head_ptr_o   (head_ptr),
        .count_o      (count)
`endif
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request depends on the registered count, so a fresh push cannot bypass.
    always_comb begin
        state_next     = state;
        ctrl_request_o = 1'b0;
        pop            = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                if (!empty_o && ctrl_idle_i) begin
                    ctrl_request_o = 1'b1;
                    state_next     = DRAIN_WAIT_DONE;
                end
            end
            DRAIN_WAIT_DONE: begin
                if (ctrl_done_i) begin
                    pop        = 1'b1;
                    state_next = DRAIN_IDLE;
                end
            end
            default: begin
                state_next = DRAIN_IDLE;
            end
        endcase
    end

    assign ctrl_data_o    = head_entry.data;
    assign ctrl_address_o = head_entry.address;
    assign ctrl_width_o   = head_entry.width;

`ifdef STORE_BUFFER_FORWARDING_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) &&
                is_word_store(entries[fwd_idx].width) &&
                (entries[fwd_idx].address == fwd_address_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = entries[fwd_idx].data;
            end
        end
    end
`else
    logic unused_fwd_address;

    assign unused_fwd_address = ^fwd_address_i;
    assign fwd_hit_o          = 1'b0;
    assign fwd_data_o         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_store_buffer                                              |
// | Description : Directed self-checking bench for store_buffer (DEPTH=4).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_request;
    logic [65:0] packet;
    logic        full;
    logic        empty;
    logic        ctrl_request;
    logic [31:0] ctrl_data;
    logic [31:0] ctrl_address;
    logic [1:0]  ctrl_width;
    logic        ctrl_idle;
    logic        ctrl_done;
    logic [31:0] fwd_address;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int errors = 0;
    int checks = 0;

    store_buffer #(
        .DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .push_request_i (push_request),
        .packet_i       (packet),
        .full_o         (full),
        .empty_o        (empty),
        .ctrl_request_o (ctrl_request),
        .ctrl_data_o    (ctrl_data),
        .ctrl_address_o (ctrl_address),
        .ctrl_width_o   (ctrl_width),
        .ctrl_idle_i    (ctrl_idle),
        .ctrl_done_i    (ctrl_done),
        .fwd_address_i  (fwd_address),
        .fwd_hit_o      (fwd_hit),
        .fwd_data_o     (fwd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        push;
        logic [65:0] pkt;
        logic        idle;
        logic        done;
        logic        e_full;
        logic        e_empty;
        logic        e_req;
        logic        chk_head;
        logic [65:0] e_head;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic [65:0] pk, input logic id,
                                input logic dn, input logic ef, input logic ee,
                                input logic er, input logic ch, input logic [65:0] eh);
        vec_t v;
        v.push = p; v.pkt = pk; v.idle = id; v.done = dn;
        v.e_full = ef; v.e_empty = ee; v.e_req = er; v.chk_head = ch; v.e_head = eh;
        return v;
    endfunction

    function automatic logic [65:0] wpkt(input int k);
        return {32'hA000_0000 + 32'(k), 32'h0000_3000 + 32'(4 * k), 2'b10};
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [65:0] pk);
        push_request = 1'b1;
        packet       = pk;
        ctrl_idle    = 1'b0;
        ctrl_done    = 1'b0;
        @(posedge clk); #1;
        push_request = 1'b0;
    endtask

    // Wait (bounded) for a request, check head fields, then return done.
    task automatic drain_one(input logic [65:0] exp, input logic do_push, input logic [65:0] ppkt);
        int n = 0;
        push_request = 1'b0;
        ctrl_done    = 1'b0;
        ctrl_idle    = 1'b1;
        #1;
        while (!ctrl_request && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_request", {65'd0, ctrl_request}, 66'd1);
        chk("drain_head", {ctrl_data, ctrl_address, ctrl_width}, exp);
        @(posedge clk); #1;
        ctrl_idle    = 1'b0;
        ctrl_done    = 1'b1;
        push_request = do_push;
        packet       = ppkt;
        #1;
        chk("wait_no_request", {65'd0, ctrl_request}, 66'd0);
        @(posedge clk); #1;
        ctrl_done    = 1'b0;
        push_request = 1'b0;
    endtask

    localparam logic [65:0] PA = {32'hDEAD_BEEF, 32'h8000_0000, 2'b10};
    localparam logic [65:0] B1 = {32'h1111_0001, 32'h0000_1000, 2'b00};
    localparam logic [65:0] B2 = {32'h1111_0002, 32'h0000_1004, 2'b01};
    localparam logic [65:0] B3 = {32'h1111_0003, 32'h0000_1008, 2'b10};
    localparam logic [65:0] B4 = {32'h1111_0004, 32'h0000_100C, 2'b11};
    localparam logic [65:0] B5 = {32'h1111_0005, 32'h0000_1010, 2'b10};
    localparam logic [65:0] PC = {32'hCAFE_F00D, 32'h0000_2000, 2'b10};
    localparam logic [65:0] Z  = 66'd0;

    vec_t vecs [26];

    initial begin
        vecs[0]  = mk(1, PA, 1, 0, 0, 1, 0, 0, Z);
        vecs[1]  = mk(0, Z,  1, 0, 0, 0, 1, 1, PA);
        vecs[2]  = mk(0, Z,  1, 0, 0, 0, 0, 1, PA);
        vecs[3]  = mk(0, Z,  1, 1, 0, 0, 0, 1, PA);
        vecs[4]  = mk(0, Z,  1, 0, 0, 1, 0, 0, Z);
        vecs[5]  = mk(1, B1, 0, 0, 0, 1, 0, 0, Z);
        vecs[6]  = mk(1, B2, 0, 0, 0, 0, 0, 1, B1);
        vecs[7]  = mk(1, B3, 0, 0, 0, 0, 0, 1, B1);
        vecs[8]  = mk(1, B4, 0, 0, 0, 0, 0, 1, B1);
        vecs[9]  = mk(1, B5, 0, 0, 1, 0, 0, 1, B1);
        vecs[10] = mk(0, Z,  0, 0, 1, 0, 0, 1, B1);
        vecs[11] = mk(0, Z,  1, 0, 1, 0, 1, 1, B1);
        vecs[12] = mk(0, Z,  1, 1, 1, 0, 0, 1, B1);
        vecs[13] = mk(0, Z,  1, 0, 0, 0, 1, 1, B2);
        vecs[14] = mk(0, Z,  1, 1, 0, 0, 0, 1, B2);
        vecs[15] = mk(0, Z,  1, 0, 0, 0, 1, 1, B3);
        vecs[16] = mk(0, Z,  1, 1, 0, 0, 0, 1, B3);
        vecs[17] = mk(0, Z,  1, 0, 0, 0, 1, 1, B4);
        vecs[18] = mk(0, Z,  1, 1, 0, 0, 0, 1, B4);
        vecs[19] = mk(0, Z,  1, 0, 0, 1, 0, 0, Z);
        vecs[20] = mk(1, PC, 0, 1, 0, 1, 0, 0, Z);
        vecs[21] = mk(0, Z,  0, 1, 0, 0, 0, 1, PC);
        vecs[22] = mk(0, Z,  0, 0, 0, 0, 0, 1, PC);
        vecs[23] = mk(0, Z,  1, 0, 0, 0, 1, 1, PC);
        vecs[24] = mk(0, Z,  1, 1, 0, 0, 0, 1, PC);
        vecs[25] = mk(0, Z,  0, 0, 0, 1, 0, 0, Z);

        rst_n        = 1'b0;
        push_request = 1'b0;
        packet       = '0;
        ctrl_idle    = 1'b0;
        ctrl_done    = 1'b0;
        fwd_address  = 32'h8000_0010;
        #1;
        chk("reset_empty", {65'd0, empty}, 66'd1);
        chk("reset_full", {65'd0, full}, 66'd0);
        chk("reset_request", {65'd0, ctrl_request}, 66'd0);
        chk("reset_fwd_hit", {65'd0, fwd_hit}, 66'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single store, fill/overflow/drain order, done ignored while idle.
        for (int i = 0; i < 26; i++) begin
            push_request = vecs[i].push;
            packet       = vecs[i].pkt;
            ctrl_idle    = vecs[i].idle;
            ctrl_done    = vecs[i].done;
            #1;
            chk($sformatf("vec%0d_full", i), {65'd0, full}, {65'd0, vecs[i].e_full});
            chk($sformatf("vec%0d_empty", i), {65'd0, empty}, {65'd0, vecs[i].e_empty});
            chk($sformatf("vec%0d_request", i), {65'd0, ctrl_request}, {65'd0, vecs[i].e_req});
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d_head", i), {ctrl_data, ctrl_address, ctrl_width}, vecs[i].e_head);
            end
            @(posedge clk); #1;
        end
        push_request = 1'b0;
        ctrl_done    = 1'b0;

        // Full buffer: push coinciding with completion is dropped.
        for (int k = 0; k < 4; k++) push_one(wpkt(20 + k));
        chk("full_after_4", {65'd0, full}, 66'd1);
        ctrl_idle = 1'b1;
        #1;
        chk("full_request", {65'd0, ctrl_request}, 66'd1);
        @(posedge clk); #1;
        ctrl_idle    = 1'b0;
        ctrl_done    = 1'b1;
        push_request = 1'b1;
        packet       = wpkt(99);
        #1;
        chk("full_held_during_pop", {65'd0, full}, 66'd1);
        @(posedge clk); #1;
        ctrl_done    = 1'b0;
        push_request = 1'b0;
        chk("full_cleared", {65'd0, full}, 66'd0);
        chk("not_empty_3", {65'd0, empty}, 66'd0);
        for (int k = 1; k < 4; k++) drain_one(wpkt(20 + k), 1'b0, Z);
        chk("empty_after_3", {65'd0, empty}, 66'd1);

        // Wrap-around with simultaneous push and pop.
        push_one(wpkt(0));
        push_one(wpkt(1));
        for (int k = 0; k < 6; k++) begin
            drain_one(wpkt(k), 1'b1, wpkt(k + 2));
            chk($sformatf("wrap%0d_not_full", k), {65'd0, full}, 66'd0);
            chk($sformatf("wrap%0d_not_empty", k), {65'd0, empty}, 66'd0);
        end
        drain_one(wpkt(6), 1'b0, Z);
        drain_one(wpkt(7), 1'b0, Z);
        chk("wrap_empty", {65'd0, empty}, 66'd1);

        // Asynchronous reset while a store is outstanding.
        for (int k = 0; k < 3; k++) push_one(wpkt(40 + k));
        ctrl_idle = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_wait", {65'd0, ctrl_request}, 66'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_empty", {65'd0, empty}, 66'd1);
        chk("midreset_full", {65'd0, full}, 66'd0);
        chk("midreset_request", {65'd0, ctrl_request}, 66'd0);
        chk("midreset_fwd_hit", {65'd0, fwd_hit}, 66'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        ctrl_idle = 1'b0;
        ctrl_done = 1'b1;
        @(posedge clk); #1;
        ctrl_done = 1'b0;
        chk("late_done_empty", {65'd0, empty}, 66'd1);
        ctrl_idle = 1'b1;
        #1;
        chk("late_done_request", {65'd0, ctrl_request}, 66'd0);
        push_one(PC);
        drain_one(PC, 1'b0, Z);

`ifdef STORE_BUFFER_FORWARDING_EN
        push_one({32'h0000_0011, 32'h8000_0010, 2'b10});
        push_one({32'h0000_0022, 32'h8000_0010, 2'b10});
        fwd_address = 32'h8000_0010;
        #1;
        chk("fwd_hit_word", {65'd0, fwd_hit}, 66'd1);
        chk("fwd_youngest", {34'd0, fwd_data}, {34'd0, 32'h0000_0022});
        push_one({32'h0000_0033, 32'h8000_0010, 2'b00});
        #1;
        chk("fwd_byte_skipped", {34'd0, fwd_data}, {34'd0, 32'h0000_0022});
        fwd_address = 32'h8000_0014;
        #1;
        chk("fwd_miss_hit", {65'd0, fwd_hit}, 66'd0);
        chk("fwd_miss_data", {34'd0, fwd_data}, 66'd0);
        fwd_address = 32'h8000_0010;
        drain_one({32'h0000_0011, 32'h8000_0010, 2'b10}, 1'b0, Z);
        #1;
        chk("fwd_after_pop", {34'd0, fwd_data}, {34'd0, 32'h0000_0022});
        drain_one({32'h0000_0022, 32'h8000_0010, 2'b10}, 1'b0, Z);
        #1;
        chk("fwd_byte_only_hit", {65'd0, fwd_hit}, 66'd0);
        chk("fwd_byte_only_data", {34'd0, fwd_data}, 66'd0);
        drain_one({32'h0000_0033, 32'h8000_0010, 2'b00}, 1'b0, Z);
`else
        push_one({32'h0000_0011, 32'h8000_0010, 2'b10});
        fwd_address = 32'h8000_0010;
        #1;
        chk("fwd_off_hit", {65'd0, fwd_hit}, 66'd0);
        chk("fwd_off_data", {34'd0, fwd_data}, 66'd0);
        drain_one({32'h0000_0011, 32'h8000_0010, 2'b10}, 1'b0, Z);
`endif
        chk("final_empty", {65'd0, empty}, 66'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries; must be a power of 2 and at least 2.
REQ-002 SHALL have port clk_i, input, 1 bit: clock.
REQ-003 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port push_request_i, input, 1 bit: producer requests a push.
REQ-005 SHALL have port packet_i, input, 66 bits: {data[31:0], address[31:0], width[1:0]}, packed as store_buffer_entry_t.
REQ-006 SHALL have port full_o, output, 1 bit: all DEPTH entries occupied.
REQ-007 SHALL have port empty_o, output, 1 bit: no entries occupied.
REQ-008 SHALL have port ctrl_request_o, output, 1 bit: single-cycle store request to the memory store controller.
REQ-009 SHALL have ports ctrl_data_o, ctrl_address_o, ctrl_width_o, outputs, 32, 32 and 2 bits: head entry fields.
REQ-010 SHALL have port ctrl_idle_i, input, 1 bit: controller can accept a request.
REQ-011 SHALL have port ctrl_done_i, input, 1 bit: single-cycle pulse, outstanding store completed.
REQ-012 SHALL have ports fwd_address_i (input, 32), fwd_hit_o (output, 1) and fwd_data_o (output, 32): load forwarding lookup.

Function
REQ-013 SHALL accept a push when push_request_i=1 and full_o=0; the packet is written at the tail, and the tail pointer and count increment at the next clock edge.
REQ-014 SHALL silently ignore push_request_i while full_o=1; no state changes.
REQ-015 SHALL derive full_o (count==DEPTH) and empty_o (count==0) from the registered count only; a pop in the same cycle does not clear full_o early.
REQ-016 SHALL keep count unchanged on a simultaneous accepted push and pop; both pointers advance.
REQ-017 SHALL wrap head and tail pointers modulo DEPTH, with no extra cycle at wrap-around.
REQ-018 SHALL implement the drain FSM {IDLE, WAIT_DONE}.
- IDLE: if empty_o=0 and ctrl_idle_i=1, assert ctrl_request_o for exactly 1 cycle and move to WAIT_DONE.
- WAIT_DONE: ctrl_request_o=0; on ctrl_done_i=1, pop the head and return to IDLE.
REQ-019 SHALL drive ctrl_data_o, ctrl_address_o and ctrl_width_o from the head entry at all times, stable from request until done.
REQ-020 SHALL provide no bypass: a packet pushed into an empty buffer at cycle t produces ctrl_request_o no earlier than cycle t+1.
REQ-021 SHALL give a minimum throughput of one store per 2 cycles when ctrl_done_i arrives in the cycle after the request.
REQ-022 SHALL ignore ctrl_done_i while in IDLE.
REQ-023 SHALL encode width per store_width_t: 00 byte, 01 half, 10 word; 11 SHALL be stored and forwarded unchanged, without checking.

Reset
REQ-024 SHALL, on rst_n_i=0, immediately set head=0, tail=0, count=0, state=IDLE, ctrl_request_o=0, empty_o=1, full_o=0, fwd_hit_o=0.
REQ-025 SHALL discard all entries on reset mid-operation, including an outstanding WAIT_DONE store; a later ctrl_done_i SHALL be ignored; entry storage is not reset.

Configuration
REQ-026 SHALL, with STORE_BUFFER_FORWARDING_EN defined, compare fwd_address_i combinationally against all valid word-width entries.
- fwd_hit_o=1 on any match; fwd_data_o returns the youngest matching entry's data.
- With no match: fwd_hit_o=0 and fwd_data_o=0.
REQ-027 SHALL, without STORE_BUFFER_FORWARDING_EN, tie fwd_hit_o=0 and fwd_data_o=0 and synthesize no comparators.

Structure
REQ-028 SHALL define store_width_t, store_buffer_entry_t and the drain FSM enum in load_store_unit_pkg.
REQ-029 SHALL place the circular storage with its pointers and count in sub-module store_buffer_fifo; the drain FSM and forwarding logic SHALL live in store_buffer.

Verification
REQ-030 SHALL cover: push {0xDEADBEEF, 0x8000_0000, 10} into an empty buffer with ctrl_idle_i=1 -> ctrl_request_o high exactly 1 cycle, one cycle after the push, with those fields.
REQ-031 SHALL cover: DEPTH=4, 5 pushes with ctrl_idle_i=0 -> full_o=1 after the 4th; the 5th is dropped; the drain later emits exactly 4 stores in order.
REQ-032 SHALL cover: buffer full, push and ctrl_done_i in the same cycle -> push ignored, count becomes 3, full_o=0 next cycle.
REQ-033 SHALL cover: 6 push/drain cycles with DEPTH=4 -> pointer wrap-around with data order preserved.
REQ-034 SHALL cover: reset asserted in WAIT_DONE with 3 entries -> empty_o=1, ctrl_request_o=0 immediately; a following ctrl_done_i has no effect.
REQ-035 SHALL cover, with forwarding enabled: two word stores to 0x8000_0010 (0x11, then 0x22) -> fwd_hit_o=1, fwd_data_o=0x22; a byte store to the same address -> no hit.
